// File: rtl/raster_checker.sv
// rtl/raster_checker.sv - receive-side raster scan checker with framing pulses and frame/error counts
module raster_checker #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32,
  parameter int FCNT_W = 16,
  parameter int ECNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [$clog2(HEIGHT)-1:0] row_counter,
  input  logic [$clog2(WIDTH)-1:0]  column_counter,
  output logic                      locked,
  output logic                      sol,
  output logic                      eol,
  output logic                      sof,
  output logic                      eof,
  output logic [FCNT_W-1:0]         frame_count,
  output logic                      error,
  output logic [ECNT_W-1:0]         error_count
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t            r_state;
  logic [RW-1:0]     r_p_row;
  logic [CW-1:0]     r_p_col;
  logic              r_p_en;
  logic              r_locked, r_sol, r_eol, r_sof, r_eof, r_error;
  logic [FCNT_W-1:0] r_frame_count;
  logic [ECNT_W-1:0] r_error_count;

  logic              w_col_oob, w_row_oob;
  logic [RW-1:0]     w_succ_row, w_exp_row;
  logic [CW-1:0]     w_succ_col, w_exp_col;
  logic              w_match, w_first_col, w_last_col, w_first_row, w_last_row;

  // Out-of-range codes only exist when the dimension is not a power of two.
  generate
    if ((1 << CW) != WIDTH) begin : g_col_chk
      assign w_col_oob = column_counter > LAST_COL;
    end else begin : g_col_full
      assign w_col_oob = 1'b0;
    end
    if ((1 << RW) != HEIGHT) begin : g_row_chk
      assign w_row_oob = row_counter > LAST_ROW;
    end else begin : g_row_full
      assign w_row_oob = 1'b0;
    end
  endgenerate

  always_comb begin
    w_succ_row = r_p_row;
    w_succ_col = r_p_col + CW'(1);
    if (r_p_col == LAST_COL) begin
      w_succ_col = '0;
      w_succ_row = (r_p_row == LAST_ROW) ? '0 : r_p_row + RW'(1);
    end
  end

  assign w_exp_row   = r_p_en ? w_succ_row : r_p_row;
  assign w_exp_col   = r_p_en ? w_succ_col : r_p_col;
  assign w_match     = !w_col_oob && !w_row_oob &&
                       (row_counter == w_exp_row) && (column_counter == w_exp_col);
  assign w_first_col = (column_counter == '0);
  assign w_last_col  = (column_counter == LAST_COL);
  assign w_first_row = (row_counter == '0);
  assign w_last_row  = (row_counter == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= SEARCH;
      r_p_row       <= '0;
      r_p_col       <= '0;
      r_p_en        <= 1'b0;
      r_locked      <= 1'b0;
      r_sol         <= 1'b0;
      r_eol         <= 1'b0;
      r_sof         <= 1'b0;
      r_eof         <= 1'b0;
      r_error       <= 1'b0;
      r_frame_count <= '0;
      r_error_count <= '0;
    end else begin
      r_p_row <= row_counter;
      r_p_col <= column_counter;
      r_p_en  <= enable;
      r_sol   <= 1'b0;
      r_eol   <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        SEARCH: begin
          if (w_first_row && w_first_col) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
            r_sol    <= 1'b1;
            r_sof    <= 1'b1;
          end
        end
        LOCKED: begin
          if (!w_match) begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
            r_error  <= 1'b1;
            if (r_error_count != '1)
              r_error_count <= r_error_count + ECNT_W'(1);
          end else if (r_p_en) begin
            // Pulses mark a freshly arrived coordinate, not a held one.
            r_sol <= w_first_col;
            r_eol <= w_last_col;
            r_sof <= w_first_row && w_first_col;
            r_eof <= w_last_row && w_last_col;
            if (w_last_row && w_last_col)
              r_frame_count <= r_frame_count + FCNT_W'(1);
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  assign locked      = r_locked;
  assign sol         = r_sol;
  assign eol         = r_eol;
  assign sof         = r_sof;
  assign eof         = r_eof;
  assign error       = r_error;
  assign frame_count = r_frame_count;
  assign error_count = r_error_count;

endmodule

// File: tb/tb_raster_checker.sv
// tb/tb_raster_checker.sv - scoreboard bench for raster_checker (32x32 and 5x3 instances)
module tb_raster_checker;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        b_rst, b_en;
  logic [4:0]  b_row, b_col;
  logic        b_locked, b_sol, b_eol, b_sof, b_eof, b_err;
  logic [15:0] b_fc;
  logic [7:0]  b_ec;

  logic        s_rst, s_en;
  logic [1:0]  s_row;
  logic [2:0]  s_col;
  logic        s_locked, s_sol, s_eol, s_sof, s_eof, s_err;
  logic [3:0]  s_fc;
  logic [3:0]  s_ec;

  raster_checker u_big (
    .clk(clk), .rst(b_rst), .enable(b_en), .row_counter(b_row), .column_counter(b_col),
    .locked(b_locked), .sol(b_sol), .eol(b_eol), .sof(b_sof), .eof(b_eof),
    .frame_count(b_fc), .error(b_err), .error_count(b_ec)
  );

  raster_checker #(.WIDTH(5), .HEIGHT(3), .FCNT_W(4), .ECNT_W(4)) u_small (
    .clk(clk), .rst(s_rst), .enable(s_en), .row_counter(s_row), .column_counter(s_col),
    .locked(s_locked), .sol(s_sol), .eol(s_eol), .sof(s_sof), .eof(s_eof),
    .frame_count(s_fc), .error(s_err), .error_count(s_ec)
  );

  typedef struct {
    logic [4:0] bits;
    int         f;
    int         e;
  } exp_t;

  localparam logic [4:0] SOL = 5'b10000;
  localparam logic [4:0] EOL = 5'b01000;
  localparam logic [4:0] SOF = 5'b00100;
  localparam logic [4:0] EOF = 5'b00010;
  localparam logic [4:0] ERR = 5'b00001;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  // Bench-side counter position and expected lock/count state, index 0 = 32x32, 1 = 5x3.
  int   br[2], bc[2], ef[2], ee[2];
  int   wd[2]    = '{32, 5};
  int   ht[2]    = '{32, 3};
  int   fmask[2] = '{65535, 15};
  int   emax[2]  = '{255, 15};
  bit   lk[2], pe[2];

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic push(input int s, input logic [4:0] bits);
    exp_t x;
    if (bits == 5'b0) return;
    if (bits[1]) ef[s] = (ef[s] + 1) & fmask[s];
    if (bits[0] && ee[s] < emax[s]) ee[s] = ee[s] + 1;
    x.bits = bits;
    x.f    = ef[s];
    x.e    = ee[s];
    if (s == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic drive(input int s, input bit r, input bit e, input int row, input int col);
    @(negedge clk);
    if (s == 0) begin
      b_rst = r; b_en = e; b_row = row[4:0]; b_col = col[4:0];
    end else begin
      s_rst = r; s_en = e; s_row = row[1:0]; s_col = col[2:0];
    end
  endtask

  task automatic advance(input int s);
    if (bc[s] == wd[s] - 1) begin
      bc[s] = 0;
      br[s] = (br[s] == ht[s] - 1) ? 0 : br[s] + 1;
    end else begin
      bc[s] = bc[s] + 1;
    end
  endtask

  task automatic step(input int s, input bit e);
    logic [4:0] bits;
    bits = 5'b0;
    drive(s, 1'b0, e, br[s], bc[s]);
    if (!lk[s]) begin
      if (br[s] == 0 && bc[s] == 0) begin
        bits  = SOL | SOF;
        lk[s] = 1'b1;
      end
    end else if (pe[s]) begin
      if (bc[s] == 0)                                  bits = bits | SOL;
      if (bc[s] == wd[s] - 1)                          bits = bits | EOL;
      if (br[s] == 0 && bc[s] == 0)                    bits = bits | SOF;
      if (br[s] == ht[s] - 1 && bc[s] == wd[s] - 1)    bits = bits | EOF;
    end
    push(s, bits);
    pe[s] = e;
    if (e) advance(s);
  endtask

  task automatic inject(input int s, input int row, input int col);
    drive(s, 1'b0, 1'b1, row, col);
    lk[s] = 1'b0;
    push(s, ERR);
    pe[s] = 1'b1;
    advance(s);
  endtask

  task automatic reset_at(input int s);
    drive(s, 1'b1, 1'b1, br[s], bc[s]);
    br[s] = 0; bc[s] = 0; lk[s] = 1'b0; pe[s] = 1'b0; ef[s] = 0; ee[s] = 0;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_big
    logic [4:0] act;
    exp_t       x;
    act = {b_sol, b_eol, b_sof, b_eof, b_err};
    if (act != 5'b0) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL big_unexpected_pulse got=%b want=none", act);
      end else begin
        x = q0.pop_front();
        if (act != x.bits || int'(b_fc) != x.f || int'(b_ec) != x.e) begin
          bad++;
          $display("FAIL big_pulse got=%b/f%0d/e%0d want=%b/f%0d/e%0d",
                   act, b_fc, b_ec, x.bits, x.f, x.e);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_small
    logic [4:0] act;
    exp_t       x;
    act = {s_sol, s_eol, s_sof, s_eof, s_err};
    if (act != 5'b0) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL small_unexpected_pulse got=%b want=none", act);
      end else begin
        x = q1.pop_front();
        if (act != x.bits || int'(s_fc) != x.f || int'(s_ec) != x.e) begin
          bad++;
          $display("FAIL small_pulse got=%b/f%0d/e%0d want=%b/f%0d/e%0d",
                   act, s_fc, s_ec, x.bits, x.f, x.e);
        end
      end
    end
  end

  initial begin
    b_rst = 1'b1; b_en = 1'b0; b_row = '0; b_col = '0;
    s_rst = 1'b1; s_en = 1'b0; s_row = '0; s_col = '0;
    for (int i = 0; i < 2; i++) begin
      br[i] = 0; bc[i] = 0; ef[i] = 0; ee[i] = 0; lk[i] = 1'b0; pe[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", int'(b_locked), 0);
    chk("rst_pulses", int'({b_sol, b_eol, b_sof, b_eof, b_err}), 0);
    chk("rst_fcnt", int'(b_fc), 0);
    chk("rst_ecnt", int'(b_ec), 0);
    chk("rst_small_locked", int'(s_locked), 0);

    // one full 32x32 frame
    repeat (1024) step(0, 1'b1);
    settle();
    chk("frame_locked", int'(b_locked), 1);
    chk("frame_fcnt", int'(b_fc), 1);
    chk("frame_ecnt", int'(b_ec), 0);

    // enable low for 10 clocks at (3,7)
    while (!(br[0] == 3 && bc[0] == 7)) step(0, 1'b1);
    repeat (10) step(0, 1'b0);
    settle();
    chk("hold_locked", int'(b_locked), 1);
    chk("hold_error", int'(b_err), 0);
    chk("hold_ecnt", int'(b_ec), 0);
    step(0, 1'b1);
    step(0, 1'b1);
    settle();
    chk("resume_locked", int'(b_locked), 1);

    // column jumps by 2 at (5,10), relock at next (0,0)
    while (!(br[0] == 5 && bc[0] == 10)) step(0, 1'b1);
    inject(0, 5, 12);
    settle();
    chk("skip_error", int'(b_err), 1);
    chk("skip_locked", int'(b_locked), 0);
    chk("skip_ecnt", int'(b_ec), 1);
    do step(0, 1'b1); while (!lk[0]);
    settle();
    chk("relock_locked", int'(b_locked), 1);
    chk("relock_fcnt", int'(b_fc), 1);

    // reset mid-frame at (20,4)
    while (!(br[0] == 20 && bc[0] == 4)) step(0, 1'b1);
    reset_at(0);
    settle();
    chk("midrst_locked", int'(b_locked), 0);
    chk("midrst_pulses", int'({b_sol, b_eol, b_sof, b_eof, b_err}), 0);
    chk("midrst_fcnt", int'(b_fc), 0);
    chk("midrst_ecnt", int'(b_ec), 0);
    step(0, 1'b1);
    settle();
    chk("postrst_locked", int'(b_locked), 1);

    // 300 error/relock pairs: count saturates at 255, pulse continues
    repeat (299) begin
      inject(0, 0, 9);
      br[0] = 0;
      bc[0] = 0;
      step(0, 1'b1);
    end
    inject(0, 0, 9);
    settle();
    chk("sat_error", int'(b_err), 1);
    chk("sat_ecnt", int'(b_ec), 255);
    chk("sat_locked", int'(b_locked), 0);

    // 5x3 raster: two frames, then out-of-range column 5
    repeat (30) step(1, 1'b1);
    settle();
    chk("small_fcnt", int'(s_fc), 2);
    chk("small_ecnt", int'(s_ec), 0);
    chk("small_locked", int'(s_locked), 1);
    inject(1, br[1], 5);
    settle();
    chk("small_oob_error", int'(s_err), 1);
    chk("small_oob_ecnt", int'(s_ec), 1);
    chk("small_oob_locked", int'(s_locked), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("big_queue_drained", q0.size(), 0);
    chk("small_queue_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
